// File: rtl/wfg_capture_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wfg_capture_spi_pkg
// Brief    : Shared types and helpers for the SPI capture receiver.
// Revision : 1.0 - initial release
// ============================================================================
package wfg_capture_spi_pkg;

  // Frame size selector as carried by cfg_dff_q_i
  typedef enum logic [1:0] {
    DFF_8  = 2'd0,
    DFF_16 = 2'd1,
    DFF_24 = 2'd2,
    DFF_32 = 2'd3
  } dff_e;

  // Frame FSM states
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int MAX_FRAME_BITS = 32;

  // Number of bits in one frame for a given frame-size selector
  function automatic logic [5:0] dff_bits(input dff_e dff);
    logic [5:0] bits;
    bits = 6'd32;
    case (dff)
      DFF_8:   bits = 6'd8;
      DFF_16:  bits = 6'd16;
      DFF_24:  bits = 6'd24;
      DFF_32:  bits = 6'd32;
      default: bits = 6'd32;
    endcase
    return bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wfg_capture_spi_if.sv
`default_nettype none
// ============================================================================
// Module   : wfg_capture_spi_if
// Brief    : AXI-Stream link from the SPI capture receiver to the recorder.
// Revision : 1.0 - initial release
// ============================================================================
interface wfg_capture_spi_if #(
  parameter int AXIS_DATA_WIDTH = 32
);

  logic                       tvalid;
  logic                       tready;
  logic [AXIS_DATA_WIDTH-1:0] tdata;
  logic                       tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface
`default_nettype wire

// File: rtl/wfg_capture_spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : wfg_capture_spi_sync
// Brief    : Two-flop synchroniser plus one edge-detect stage producing
//            single-cycle rise/fall pulses. Edge pulses are suppressed until
//            the chain has been refilled after reset, so the all-zero reset
//            contents cannot fake an edge against an idle-high pin.
// Revision : 1.0 - initial release
// ============================================================================
module wfg_capture_spi_sync (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic async_i,
  output logic      sync_o,
  output logic      rise_o,
  output logic      fall_o
);

  logic       meta_q,  meta_d;
  logic       sync_q,  sync_d;
  logic       dly_q,   dly_d;
  logic [1:0] prime_q, prime_d;
  logic       primed;

  // Next-state for the synchroniser chain and the post-reset priming counter
  always_comb begin
    meta_d  = async_i;
    sync_d  = meta_q;
    dly_d   = sync_q;
    prime_d = prime_q;
    if (prime_q != 2'd3) begin
      prime_d = prime_q + 2'd1;
    end
  end

  // Synchroniser, edge-detect and priming registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      dly_q   <= 1'b0;
      prime_q <= 2'd0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      prime_q <= prime_d;
    end
  end

  assign primed = (prime_q == 2'd3);
  assign sync_o = sync_q;
  assign rise_o = primed &  sync_q & ~dly_q;
  assign fall_o = primed & ~sync_q &  dly_q;

endmodule
`default_nettype wire

// File: rtl/wfg_capture_spi.sv
`default_nettype none
// ============================================================================
// Module   : wfg_capture_spi
// Brief    : SPI slave receiver. Oversamples SCLK/CS/SDI in the core clock,
//            deserialises 8/16/24/32-bit frames and emits them on an
//            AXI-Stream master port, with tlast on the final word of each
//            chip-select window.
// Options  : WFG_CAPTURE_SPI_PARTIAL_EN - emit a zero-padded partial word at
//            chip-select release instead of discarding it.
// Revision : 1.0 - initial release
// ============================================================================
module wfg_capture_spi
  import wfg_capture_spi_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       ctrl_en_q_i,
  input  wire logic       cfg_cpol_q_i,
  input  wire logic       cfg_cpha_q_i,
  input  wire logic       cfg_lsbfirst_q_i,
  input  wire logic [1:0] cfg_dff_q_i,
  input  wire logic       cfg_sspol_q_i,
  input  wire logic       wfg_capture_spi_sclk_i,
  input  wire logic       wfg_capture_spi_cs_i,
  input  wire logic       wfg_capture_spi_sdi_i,
  wfg_capture_spi_if.master axis,
  output logic            status_ovf_o,
  output logic            status_busy_o
);

  localparam int W = AXIS_DATA_WIDTH;

  // Synchronised SPI pins
  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync,   cs_rise,   cs_fall;
  logic sdi_sync,  sdi_rise,  sdi_fall;
  logic unused_sync;

  wfg_capture_spi_sync u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(wfg_capture_spi_sclk_i),
    .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  wfg_capture_spi_sync u_sync_cs (
    .clk(clk), .rst_n(rst_n), .async_i(wfg_capture_spi_cs_i),
    .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  wfg_capture_spi_sync u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .async_i(wfg_capture_spi_sdi_i),
    .sync_o(sdi_sync), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  assign unused_sync = &{1'b0, sclk_sync, cs_rise, cs_fall, sdi_rise, sdi_fall};

  // Frame state and configuration latched at window entry
  state_e      state_q,  state_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [31:0] shift_q,  shift_d;
  logic        lsb_q,    lsb_d;
  logic        rise_q,   rise_d;
  logic        sspol_q,  sspol_d;
  dff_e        dff_q,    dff_d;

  // One-entry pend buffer
  logic [31:0] pend_word_q,  pend_word_d;
  logic        pend_last_q,  pend_last_d;
  logic        pend_valid_q, pend_valid_d;

  // AXIS output register and status
  logic         tvalid_q, tvalid_d;
  logic [W-1:0] tdata_q,  tdata_d;
  logic         tlast_q,  tlast_d;
  logic         ovf_q,    ovf_d;

  // Per-cycle scratch
  logic        out_free;
  logic        sample;
  logic        word_done;
  logic [31:0] captured;
  logic [4:0]  pos;
  logic [5:0]  nbits;

  // Frame FSM, deserialiser, pend buffer and output register next-state
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    lsb_d        = lsb_q;
    rise_d       = rise_q;
    sspol_d      = sspol_q;
    dff_d        = dff_q;
    pend_word_d  = pend_word_q;
    pend_last_d  = pend_last_q;
    pend_valid_d = pend_valid_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    ovf_d        = ovf_q;
    out_free     = !tvalid_q || axis.tready;
    sample       = 1'b0;
    word_done    = 1'b0;
    captured     = shift_q;
    pos          = 5'd0;
    nbits        = dff_bits(dff_q);

    // A completed handshake empties the output unless reloaded below
    if (tvalid_q && axis.tready) begin
      tvalid_d = 1'b0;
    end

    if (!ctrl_en_q_i) begin
      state_d      = IDLE;
      bitcnt_d     = 5'd0;
      shift_d      = 32'd0;
      pend_valid_d = 1'b0;
      pend_last_d  = 1'b0;
      pend_word_d  = 32'd0;
      ovf_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_sync == cfg_sspol_q_i) begin
            state_d  = ACTIVE;
            bitcnt_d = 5'd0;
            shift_d  = 32'd0;
            lsb_d    = cfg_lsbfirst_q_i;
            rise_d   = (cfg_cpol_q_i == cfg_cpha_q_i);
            sspol_d  = cfg_sspol_q_i;
            dff_d    = dff_e'(cfg_dff_q_i);
          end
        end

        ACTIVE: begin
          sample = rise_q ? sclk_rise : sclk_fall;
          if (sample) begin
            pos = lsb_q ? bitcnt_q : 5'(nbits - 6'd1 - {1'b0, bitcnt_q});
            captured[pos] = sdi_sync;
            if ({1'b0, bitcnt_q} == nbits - 6'd1) begin
              word_done = 1'b1;
              bitcnt_d  = 5'd0;
              shift_d   = 32'd0;
            end else begin
              bitcnt_d  = bitcnt_q + 5'd1;
              shift_d   = captured;
            end
          end

          // A new word pushes any pend word out (not last) or is dropped
          if (word_done) begin
            if (!pend_valid_q) begin
              pend_word_d  = captured;
              pend_last_d  = 1'b0;
              pend_valid_d = 1'b1;
            end else if (out_free) begin
              tvalid_d     = 1'b1;
              tdata_d      = '0;
              tdata_d[31:0] = pend_word_q;
              tlast_d      = 1'b0;
              out_free     = 1'b0;
              pend_word_d  = captured;
              pend_last_d  = 1'b0;
            end else begin
              ovf_d = 1'b1;
            end
          end

          // Window close is evaluated after this cycle's bit is captured
          if (cs_sync != sspol_q) begin
            state_d = IDLE;
`ifdef WFG_CAPTURE_SPI_PARTIAL_EN
            if (bitcnt_d != 5'd0) begin
              if (!pend_valid_d) begin
                pend_word_d  = shift_d;
                pend_last_d  = 1'b1;
                pend_valid_d = 1'b1;
              end else if (out_free) begin
                tvalid_d      = 1'b1;
                tdata_d       = '0;
                tdata_d[31:0] = pend_word_d;
                tlast_d       = 1'b0;
                out_free      = 1'b0;
                pend_word_d   = shift_d;
                pend_last_d   = 1'b1;
              end else begin
                ovf_d       = 1'b1;
                pend_last_d = 1'b1;
              end
            end else if (pend_valid_d) begin
              pend_last_d = 1'b1;
            end
`else
            if (pend_valid_d) begin
              pend_last_d = 1'b1;
            end
`endif
            bitcnt_d = 5'd0;
            shift_d  = 32'd0;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // A closed pend entry drains into a free output register
    if (out_free && pend_valid_d && pend_last_d) begin
      tvalid_d      = 1'b1;
      tdata_d       = '0;
      tdata_d[31:0] = pend_word_d;
      tlast_d       = 1'b1;
      pend_valid_d  = 1'b0;
      pend_last_d   = 1'b0;
    end
  end

  // State, pend and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bitcnt_q     <= 5'd0;
      shift_q      <= 32'd0;
      lsb_q        <= 1'b0;
      rise_q       <= 1'b0;
      sspol_q      <= 1'b0;
      dff_q        <= DFF_8;
      pend_word_q  <= 32'd0;
      pend_last_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      lsb_q        <= lsb_d;
      rise_q       <= rise_d;
      sspol_q      <= sspol_d;
      dff_q        <= dff_d;
      pend_word_q  <= pend_word_d;
      pend_last_q  <= pend_last_d;
      pend_valid_q <= pend_valid_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      ovf_q        <= ovf_d;
    end
  end

  assign axis.tvalid   = tvalid_q;
  assign axis.tdata    = tdata_q;
  assign axis.tlast    = tlast_q;
  assign status_ovf_o  = ovf_q;
  assign status_busy_o = (state_q == ACTIVE);

endmodule
`default_nettype wire
